// File: rtl/cplx_operand_packer.sv
// Complex operand packer: gathers a stream of words into one
// operand frame and holds it for the complex multiplier.
module cplx_operand_packer #(
  parameter int SIZE         = 16,
  parameter int NUM_OPERANDS = 4,
  parameter int WIDTH        = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  input  logic [WIDTH-1:0]          s_data_i,
  input  logic                      s_last_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [SIZE*NUM_OPERANDS-1:0][WIDTH-1:0] operands_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int N  = SIZE * NUM_OPERANDS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_d;
  logic            wr_en;
  logic            ready_q;
  logic            err_q;
  logic [N-1:0][WIDTH-1:0] ops_q;

  // Next state, counter, error and word-write decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    if (flush_i) begin
      state_d = FILL;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        FULL: begin
          if (out_ready_i) begin
            state_d = FILL;
            cnt_d   = '0;
          end
        end
        FILL: begin
          if (s_valid_i && ready_q) begin
            if (cnt_q == CW'(N - 1)) begin
              wr_en   = 1'b1;
              state_d = FULL;
              cnt_d   = '0;
              err_d   = !s_last_i;
            end else if (s_last_i) begin
              cnt_d = '0;
              err_d = 1'b1;
            end else begin
              wr_en = 1'b1;
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_d = FILL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Control registers; ready mirrors the upcoming state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == FILL);
      err_q   <= err_d;
    end
  end

  // Frame storage; only accepted words overwrite it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ops_q <= '0;
    end else if (wr_en) begin
      ops_q[cnt_q] <= s_data_i;
    end
  end

  assign s_ready_o   = ready_q;
  assign out_valid_o = (state_q == FULL);
  assign operands_o  = ops_q;
  assign busy_o      = (cnt_q != '0) || (state_q == FULL);
  assign err_o       = err_q;

endmodule

// File: tb/tb_cplx_operand_packer.sv
// Scoreboard bench for cplx_operand_packer: random and
// directed frames against a frame-level reference model.
module tb_cplx_operand_packer;

  localparam int N = 64;
  localparam int W = 64;

  typedef logic [N-1:0][W-1:0] frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [W-1:0] s_data = '0;
  logic s_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  frame_t ops;
  logic busy;
  logic err;

  cplx_operand_packer dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .s_data_i   (s_data),
    .s_last_i   (s_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .operands_o (ops),
    .busy_o     (busy),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // reference model state
  frame_t exp_q[$];
  logic [W-1:0] cur[$];
  int exp_err = 0;

  // monitor state
  int cyc = 0;
  int err_seen = 0;
  int vcycles = 0;
  int rise_q[$];
  bit seen = 0;
  frame_t held;

  task automatic chk(input bit ok, input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_frame(input string nm, input frame_t a,
                           input frame_t e);
    int k;
    k = -1;
    for (int i = 0; i < N; i++)
      if (k < 0 && a[i] !== e[i]) k = i;
    total++;
    if (k < 0) passed++;
    else $display("FAIL %s word %0d: got %h expected %h",
                  nm, k, a[k], e[k]);
  endtask

  // Frame-level model: words gather in order; a frame is
  // exactly N words, a misplaced last marker is an error.
  task automatic model_accept(input logic [W-1:0] d,
                              input bit last);
    frame_t f;
    if (cur.size() == N - 1) begin
      cur.push_back(d);
      for (int i = 0; i < N; i++) f[i] = cur[i];
      exp_q.push_back(f);
      cur.delete();
      if (!last) exp_err++;
    end else if (last) begin
      cur.delete();
      exp_err++;
    end else begin
      cur.push_back(d);
    end
  endtask

  task automatic send(input logic [W-1:0] d, input bit last,
                      input bit gaps);
    int n;
    if (gaps && $urandom_range(0, 3) == 0) begin
      s_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (!s_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk(1'b0, "send_timeout", '0, 64'd1);
    else model_accept(d, last);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_real();
    real r;
    r = ($itor($urandom) - 2147483648.0) /
        $itor($urandom_range(1, 1000));
    return $realtobits(r);
  endfunction

  task automatic send_frame_rand(input bit gaps);
    for (int i = 0; i < N; i++)
      send(rnd_real(), i == N - 1, gaps);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one expected frame per presentation and
  // checks the frame stays put while it is held.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 0;
    end else begin
      if (err) err_seen++;
      if (out_valid) begin
        vcycles++;
        if (!seen) begin
          seen = 1;
          rise_q.push_back(cyc);
          held = ops;
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_frame", ops[0], '0);
          end else begin
            chk_frame("frame", ops, exp_q.pop_front());
          end
        end else begin
          chk_frame("hold_stable", ops, held);
        end
      end else begin
        seen = 0;
      end
    end
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk(out_valid == 1'b0, "rst_valid", 64'(out_valid), 0);
    chk(s_ready == 1'b0, "rst_ready", 64'(s_ready), 0);
    chk(busy == 1'b0, "rst_busy", 64'(busy), 0);
    chk(err == 1'b0, "rst_err", 64'(err), 0);
    chk(ops == '0, "rst_ops", ops[0], 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk(s_ready == 1'b1, "ready_after_rst", 64'(s_ready), 1);

    // counting frame, back-to-back
    vcycles = 0;
    for (int i = 0; i < N; i++) send(64'(i), i == N - 1, 1'b0);
    @(negedge clk);
    chk(64'(vcycles) == 64'd1, "valid_one_cycle",
        64'(vcycles), 1);
    chk(busy == 1'b0, "busy_after_hs", 64'(busy), 0);
    chk(64'(err_seen) == 64'd0, "no_err", 64'(err_seen), 0);

    // held frame with downstream stalled
    out_ready = 1'b0;
    send_frame_rand(1'b1);
    for (int i = 0; i < 10; i++) begin
      chk(out_valid == 1'b1, "hold_valid", 64'(out_valid), 1);
      chk(s_ready == 1'b0, "hold_ready", 64'(s_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk(out_valid == 1'b0, "release", 64'(out_valid), 0);

    // early last marker on word 10
    for (int i = 0; i < 11; i++)
      send(rnd_real(), i == 10, 1'b0);
    chk(err == 1'b1, "early_last_err", 64'(err), 1);
    chk(busy == 1'b0, "early_last_cnt0", 64'(busy), 0);
    @(negedge clk);
    chk(err == 1'b0, "err_one_cycle", 64'(err), 0);
    send_frame_rand(1'b1);
    @(negedge clk);

    // flush mid-frame with a colliding word
    for (int i = 0; i < 30; i++) send(rnd_real(), 1'b0, 1'b1);
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 64'hdead_beef_dead_beef;
    @(negedge clk);
    flush   = 1'b0;
    s_valid = 1'b0;
    cur.delete();
    chk(busy == 1'b0, "flush_busy", 64'(busy), 0);
    chk(err == 1'b0, "flush_err", 64'(err), 0);
    send_frame_rand(1'b0);
    @(negedge clk);

    // missing last marker on the final word
    for (int i = 0; i < N; i++) send(rnd_real(), 1'b0, 1'b0);
    chk(err == 1'b1, "missing_last_err", 64'(err), 1);
    @(negedge clk);

    // three frames back-to-back, period check
    rise_q.delete();
    for (int f = 0; f < 3; f++) send_frame_rand(1'b0);
    @(negedge clk);
    if (rise_q.size() == 3) begin
      chk(rise_q[1] - rise_q[0] == 65, "period_1",
          64'(rise_q[1] - rise_q[0]), 65);
      chk(rise_q[2] - rise_q[1] == 65, "period_2",
          64'(rise_q[2] - rise_q[1]), 65);
    end else begin
      chk(1'b0, "rise_count", 64'(rise_q.size()), 3);
    end

    // reset while a frame is held
    out_ready = 1'b0;
    send_frame_rand(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk(out_valid == 1'b0, "arst_valid", 64'(out_valid), 0);
    chk(busy == 1'b0, "arst_busy", 64'(busy), 0);
    chk(s_ready == 1'b0, "arst_ready", 64'(s_ready), 0);
    chk(ops == '0, "arst_ops", ops[0], 0);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk(s_ready == 1'b0, "ready_before_edge", 64'(s_ready), 0);
    @(negedge clk);
    chk(s_ready == 1'b1, "ready_after_rel", 64'(s_ready), 1);

    // final accounting
    repeat (2) @(negedge clk);
    chk(exp_q.size() == 0, "frames_left", 64'(exp_q.size()), 0);
    chk(err_seen == exp_err, "err_total", 64'(err_seen),
        64'(exp_err));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cplx_operand_packer.md
CPLX_OPERAND_PACKER -- requirements
Module: cplx_operand_packer

Interface
REQ-001 Parameter SIZE, default 16: number of complex element pairs per frame.
REQ-002 Parameter NUM_OPERANDS, default 4: words per element pair (re1, im1, re2, im2).
REQ-003 Parameter WIDTH, default 64: bits per word (IEEE-754 double).
REQ-004 Derived N = SIZE*NUM_OPERANDS words per frame; counter width $clog2(N).
REQ-005 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_ni  in  1  asynchronous, active-low reset.
REQ-007 flush_i  in  1  synchronous discard of the partial or held frame.
REQ-008 s_valid_i  in  1  input word valid.
REQ-009 s_ready_o  out  1  packer can accept a word.
REQ-010 s_data_i  in  WIDTH  input word.
REQ-011 s_last_i  in  1  marks the final word of a frame.
REQ-012 out_valid_o  out  1  full operand frame is presented.
REQ-013 out_ready_i  in  1  downstream multiplier accepts the frame.
REQ-014 operands_o  out  [N-1:0][WIDTH-1:0]  packed frame, drives complex_matrix_mul operands_i.
REQ-015 busy_o  out  1  frame in progress or held.
REQ-016 err_o  out  1  one-cycle framing-error pulse.

Function
REQ-017 Two states SHALL exist: FILL (collecting words) and FULL (frame held for output).
REQ-018 An input transfer SHALL occur on a rising edge with s_valid_i=1 and s_ready_o=1.
REQ-019 The k-th accepted word of a frame (k=0..N-1) SHALL be registered into operands_o[k], so element i occupies indices 4i..4i+3 as re1, im1, re2, im2.
REQ-020 Gaps with s_valid_i=0 SHALL stall the word counter without changing any output.
REQ-021 s_ready_o SHALL be a register equal to (next state == FILL).
REQ-022 Accepting word N-1 SHALL move the state to FULL; out_valid_o SHALL be 1 and s_ready_o SHALL be 0 from the following cycle.
REQ-023 In FULL, operands_o and out_valid_o SHALL hold stable until out_ready_i=1 on a rising edge.
REQ-024 That output handshake SHALL return the state to FILL with the counter at 0; out_valid_o drops and s_ready_o rises on the next cycle.
REQ-025 s_last_i=1 on word k<N-1 SHALL discard the frame, reset the counter to 0, stay in FILL, and pulse err_o for one cycle.
REQ-026 s_last_i=0 on word N-1 SHALL still complete the frame per REQ-022 and pulse err_o for one cycle.
REQ-027 flush_i=1 SHALL override all other events on that edge: state FILL, counter 0, out_valid_o 0, s_ready_o 1 next cycle, no err_o, and any simultaneous input word is dropped.
REQ-028 operands_o contents SHALL be unchanged by flush and by frame discard; only words of later accepted transfers overwrite them.
REQ-029 busy_o SHALL be 1 when counter != 0 or state == FULL, else 0.
REQ-030 Sustained throughput SHALL be one frame per N+1 cycles, including the single FULL cycle, when out_ready_i=1 and s_valid_i=1.
REQ-031 No arithmetic is performed on data; words pass bit-exact.

Reset
REQ-032 While rst_ni=0: state FILL, counter 0, out_valid_o 0, s_ready_o 0, err_o 0, busy_o 0, operands_o all zero.
REQ-033 After rst_ni rises, s_ready_o SHALL become 1 on the first rising edge.
REQ-034 Reset asserted in any state SHALL abandon the current frame immediately, with no output handshake and no err_o.

Verification
REQ-035 Feed words 0..63 back-to-back with s_last_i on word 63 and out_ready_i=1 -> operands_o[k]=k, out_valid_o high for exactly 1 cycle, busy_o low after the handshake, err_o never set.
REQ-036 Complete a frame, hold out_ready_i=0 for 10 cycles -> out_valid_o=1, s_ready_o=0, and operands_o constant throughout; frame released on the cycle out_ready_i rises.
REQ-037 Assert s_last_i on word 10 -> err_o pulses once, counter 0; the next 64 clean words form a correct frame.
REQ-038 Accept 30 words, then flush_i=1 for one cycle with s_valid_i=1 -> that word is dropped, busy_o=0, err_o=0; a new 64-word frame completes normally.
REQ-039 Drop rst_ni while in FULL -> out_valid_o, busy_o, and s_ready_o go 0 asynchronously and operands_o goes 0; s_ready_o returns 1 one edge after release.
REQ-040 Send three frames back-to-back with out_ready_i=1 -> out_valid_o rises every 65 cycles, and each frame matches its input sequence; randomized real-valued words cross-checked against the $realtobits source data.
